// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin sharing of one serial transmitter between N multi-char requesters.
// Optional WAIT_TX watchdog enabled by defining TX_ARBITER_TIMEOUT_EN.
module tx_arbiter #(
    parameter int N = 3,
    parameter int W = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] char_in,
    input  logic [N-1:0]   last_in,
    input  logic           pronto_tx,
    output logic           partida_tx,
    output logic [W-1:0]   dado_tx,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   prox_char,
    output logic [N-1:0]   fim,
    output logic           ocupado,
    output logic           erro_timeout
);
    localparam int PW = $clog2(N);
    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_TX, NEXT, DONE} state_t;
    state_t state, state_n;
    logic [PW-1:0] ptr, g, win, idx;
    logic any, last_r, tmo;
    if (N < 2 || N > 8 || W < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("tx_arbiter: unsupported parameter values");
    end
    // scan from the highest offset down so the first requester after ptr wins last
    always_comb begin
        win = '0;
        idx = '0;
        any = |req;
        for (int k = N - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % N);
            if (req[idx]) win = idx;
        end
    end
`ifdef TX_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] cnt;
    logic to_r;
    assign tmo = state == WAIT_TX && !pronto_tx && cnt == CW'(TIMEOUT_CYCLES - 1);
    assign erro_timeout = to_r;
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt  <= '0;
            to_r <= 1'b0;
        end else begin
            cnt  <= (state == WAIT_TX) ? cnt + 1'b1 : '0;
            to_r <= tmo;
        end
    end
`else
    assign tmo = 1'b0;
    assign erro_timeout = 1'b0;
`endif
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = any ? LOAD : IDLE;
            LOAD:    state_n = START;
            START:   state_n = WAIT_TX;
            WAIT_TX: state_n = pronto_tx ? (last_r ? DONE : NEXT) : (tmo ? DONE : WAIT_TX);
            NEXT:    state_n = LOAD;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            g       <= '0;
            grant   <= '0;
            dado_tx <= '0;
            last_r  <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && any) begin
                g     <= win;
                grant <= N'(1) << win;
            end
            if (state == LOAD) begin
                dado_tx <= char_in[g*W +: W];
                last_r  <= last_in[g];
            end
            if (state == DONE) begin
                grant <= '0;
                ptr   <= (g == PW'(N - 1)) ? '0 : g + 1'b1;
            end
        end
    end
    assign partida_tx = state == START;
    assign prox_char  = (state == NEXT) ? grant : '0;
    assign fim        = (state == DONE) ? grant : '0;
    assign ocupado    = state != IDLE;
endmodule
